// File: rtl/counter_sequencer_if.sv
// Command/status bundle for counter_sequencer: run-control commands in,
// LED count bits and busy/done status out.
interface counter_sequencer_if;
   logic       input_start_3;
   logic       input_stop_4;
   logic       input_mode_5;
   logic [2:0] input_limit_6;
   logic       output_led1_0_7;
   logic       output_led2_0_8;
   logic       output_led3_0_9;
   logic       output_busy_10;
   logic       output_done_11;

   modport master (
      output input_start_3, input_stop_4, input_mode_5, input_limit_6,
      input  output_led1_0_7, output_led2_0_8, output_led3_0_9,
             output_busy_10, output_done_11
   );

   modport slave (
      input  input_start_3, input_stop_4, input_mode_5, input_limit_6,
      output output_led1_0_7, output_led2_0_8, output_led3_0_9,
             output_busy_10, output_done_11
   );
endinterface

// File: rtl/counter_sequencer.sv
// Start/stop/pause sequencer for the 3-bit LED counter with programmable terminal count.
// Optional tick prescaler enabled by defining COUNTER_SEQUENCER_PRESCALE_EN.
module counter_sequencer #(
   parameter int PRESCALE_DIV = 4
) (
   input  logic                  input_clock1_1,
   input  logic                  input_reset_n_2,
   counter_sequencer_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_count;
   logic [2:0] w_count_nxt;
   logic       r_busy;
   logic       r_done;
   logic       w_done_nxt;
   logic       w_tick;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   localparam logic [7:0] DIV_M1 = 8'(PRESCALE_DIV - 1);

   logic [7:0] r_presc;
   logic [7:0] w_presc_nxt;

   assign w_tick = (r_presc == DIV_M1);

   // Cleared on any entry into RUN, advances while RUN continues, frozen otherwise.
   always_comb begin
      w_presc_nxt = r_presc;
      if (w_state_nxt == S_RUN) begin
         if (r_state != S_RUN || w_tick)
            w_presc_nxt = 8'd0;
         else
            w_presc_nxt = r_presc + 8'd1;
      end
   end
`else
   // Every RUN cycle is a tick; all legal divider values are >= 1.
   assign w_tick = (PRESCALE_DIV >= 1);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!bus.input_stop_4 && bus.input_start_3) begin
               w_state_nxt = S_RUN;
               w_count_nxt = 3'd0;
            end
         end
         S_RUN: begin
            if (bus.input_stop_4) begin
               w_state_nxt = S_PAUSE;
            end else if (w_tick) begin
               if (r_count >= bus.input_limit_6) begin
                  w_done_nxt = 1'b1;
                  if (bus.input_mode_5)
                     w_state_nxt = S_DONE;
                  else
                     w_count_nxt = 3'd0;
               end else begin
                  w_count_nxt = r_count + 3'd1;
               end
            end
         end
         S_PAUSE: begin
            if (bus.input_stop_4) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = 3'd0;
            end else if (bus.input_start_3) begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.input_stop_4) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = 3'd0;
            end else if (bus.input_start_3) begin
               w_state_nxt = S_RUN;
               w_count_nxt = 3'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = 3'd0;
         end
      endcase
   end

   always_ff @(posedge input_clock1_1) begin
      if (!input_reset_n_2) begin
         r_state <= S_IDLE;
         r_count <= 3'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
         r_presc <= 8'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= w_done_nxt;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
         r_presc <= w_presc_nxt;
`endif
      end
   end

   assign bus.output_led1_0_7 = r_count[0];
   assign bus.output_led2_0_8 = r_count[1];
   assign bus.output_led3_0_9 = r_count[2];
   assign bus.output_busy_10  = r_busy;
   assign bus.output_done_11  = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random commands,
// checked every cycle against a rule-level model of the sequencer.
module tb_counter_sequencer;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   counter_sequencer_if bus();

   counter_sequencer #(.PRESCALE_DIV(4)) dut (
      .input_clock1_1  (clk),
      .input_reset_n_2 (rst_n),
      .bus             (bus)
   );

   int checks   = 0;
   int failures = 0;

   int m_mode_st;
   int m_cnt;
   int m_phase;
   bit m_done;

   function automatic int dut_count();
      return int'({bus.output_led3_0_9, bus.output_led2_0_8, bus.output_led1_0_7});
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: each edge applies reset, then stop > start > tick as stated rules.
   task automatic model_edge(input bit rs, input bit st, input bit sp, input bit md, input int lim);
      bit tick;
      m_done = 1'b0;
      if (!rs) begin
         m_mode_st = M_IDLE;
         m_cnt     = 0;
         m_phase   = 0;
      end else if (m_mode_st == M_IDLE) begin
         if (!sp && st) begin m_mode_st = M_RUN; m_cnt = 0; m_phase = 0; end
      end else if (m_mode_st == M_RUN) begin
         if (sp) begin
            m_mode_st = M_PAUSE;
         end else begin
            m_phase = (m_phase + 1) % DIV;
            tick = (m_phase == 0);
            if (tick) begin
               if (m_cnt >= lim) begin
                  m_done = 1'b1;
                  if (md) m_mode_st = M_DONE;
                  else    m_cnt = 0;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
         end
      end else begin
         if (sp) begin
            m_mode_st = M_IDLE;
            m_cnt     = 0;
         end else if (st) begin
            if (m_mode_st == M_DONE) m_cnt = 0;
            m_mode_st = M_RUN;
            m_phase   = 0;
         end
      end
   endtask

   task automatic cyc(input bit rs, input bit st, input bit sp, input bit md, input int lim);
      rst_n              = rs;
      bus.input_start_3  = st;
      bus.input_stop_4   = sp;
      bus.input_mode_5   = md;
      bus.input_limit_6  = 3'(lim);
      @(posedge clk);
      model_edge(rs, st, sp, md, lim);
      #1;
      chk("count", dut_count(), m_cnt);
      chk("busy", int'(bus.output_busy_10), int'(m_mode_st == M_RUN));
      chk("done", int'(bus.output_done_11), int'(m_done));
   endtask

   task automatic run_n(input int n, input bit md, input int lim);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, md, lim);
   endtask

   initial begin
      m_mode_st = M_IDLE;
      m_cnt     = 0;
      m_phase   = 0;
      m_done    = 1'b0;
      #1;

      // Reset state
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 3);
      chk("reset_count", dut_count(), 0);
      chk("reset_busy", int'(bus.output_busy_10), 0);
      chk("reset_done", int'(bus.output_done_11), 0);
      run_n(2, 1'b0, 3);

      // Free-run, limit 3
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3);
      chk("start_busy", int'(bus.output_busy_10), 1);
      chk("start_count", dut_count(), 0);
`ifndef COUNTER_SEQUENCER_PRESCALE_EN
      run_n(3, 1'b0, 3);
      chk("freerun_at3", dut_count(), 3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
      chk("wrap_count", dut_count(), 0);
      chk("wrap_done", int'(bus.output_done_11), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
      chk("after_wrap", dut_count(), 1);
      chk("done_cleared", int'(bus.output_done_11), 0);
`else
      run_n(3, 1'b0, 3);
      chk("presc_not_yet", dut_count(), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
      chk("presc_first_tick", dut_count(), 1);
      run_n(2, 1'b0, 3);
      // Pause 3 cycles mid-period, then resume restarts a full period
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 3);
      run_n(3, 1'b0, 3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3);
      run_n(3, 1'b0, 3);
      chk("presc_resume_hold", dut_count(), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
      chk("presc_resume_tick", dut_count(), 2);
`endif
      run_n(6 * DIV, 1'b0, 3);

      // One-shot, limit 5
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 5);
      run_n(8 * DIV, 1'b1, 5);
      chk("oneshot_hold", dut_count(), 5);
      chk("oneshot_busy", int'(bus.output_busy_10), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 5);
      chk("oneshot_restart", dut_count(), 0);
      run_n(3 * DIV, 1'b1, 5);

      // Pause at 2, wait, resume, then stop twice
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
      run_n(2 * DIV, 1'b0, 7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
      chk("pause_count", dut_count(), 2);
      run_n(10, 1'b0, 7);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
      run_n(DIV, 1'b0, 7);
      chk("resume_count", dut_count(), 3);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
      chk("stop_to_idle", dut_count(), 0);

      // start and stop together: IDLE stays, RUN pauses; reset mid-run
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 7);
      chk("both_idle_busy", int'(bus.output_busy_10), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
      run_n(2 * DIV, 1'b0, 7);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 7);
      chk("both_run_busy", int'(bus.output_busy_10), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
      run_n(2 * DIV, 1'b0, 7);
      chk("pre_reset_count", dut_count(), 4);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7);
      chk("midrun_reset", dut_count(), 0);

      // Limit lowered below the count, then limit 0 in both modes
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7);
      run_n(5 * DIV, 1'b0, 7);
      chk("before_lower", dut_count(), 5);
      run_n(DIV, 1'b0, 2);
      chk("lowered_wrap", dut_count(), 0);
      chk("lowered_done", int'(bus.output_done_11), 1);
      run_n(4 * DIV, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
      run_n(2 * DIV, 1'b1, 0);

      // Random commands against the model
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 40) != 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
